// File: rtl/uart_pkg.sv
// Shared UART definitions: control byte defaults and the rx line-buffer state
// encoding used by both the tx and rx paths.
package uart_pkg;

  localparam logic [7:0] UART_EOL = 8'h0D;
  localparam logic [7:0] UART_BS  = 8'h08;

  typedef enum logic [1:0] {
    RX_COLLECT = 2'd0,
    RX_HOLD    = 2'd1,
    RX_DISCARD = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    BYTE_DATA = 2'd0,
    BYTE_EOL  = 2'd1,
    BYTE_BS   = 2'd2
  } byte_class_t;

  function automatic byte_class_t classify_byte(input logic [7:0] b,
                                                input logic [7:0] eol,
                                                input logic [7:0] bs);
    if (b == eol) return BYTE_EOL;
    if (b == bs)  return BYTE_BS;
    return BYTE_DATA;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Line storage: DEPTH x 8, one synchronous write port and one asynchronous
// read port so the consumer sees data on the same cycle it drives the index.
module line_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rx_line_buffer.sv
// Assembles received UART bytes into one line with backspace editing and echo,
// then holds the finished line until the consumer acknowledges it.
module rx_line_buffer
  import uart_pkg::*;
#(
  parameter int         DEPTH = 16,
  parameter logic [7:0] EOL   = UART_EOL,
  parameter logic [7:0] BS    = UART_BS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       echo_full,
  output logic       echo_wr,
  output logic [7:0] echo_byte,
  output logic       line_valid,
  output logic [4:0] line_len,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       line_ack,
  output logic       overflow,
  output logic       drop
);

  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  rx_state_t   state_reg;
  logic [4:0]  count_reg;
  logic        line_valid_reg;
  logic [4:0]  line_len_reg;
  logic        echo_wr_reg;
  logic [7:0]  echo_byte_reg;
  logic        overflow_reg;
  logic        drop_reg;

  byte_class_t byte_class;
  logic        collecting;
  logic        has_room;
  logic        not_empty;
  logic        store;
  logic        echo_due;

  always_comb begin
    byte_class = classify_byte(rx_byte, EOL, BS);
    collecting = rx_valid && (state_reg == RX_COLLECT);
    has_room   = count_reg < DEPTH_C;
    not_empty  = count_reg != 5'd0;
    store      = collecting && (byte_class == BYTE_DATA) && has_room;
    // Echo only what actually changes the line: stored data, effective BS, accepted EOL.
    echo_due   = store ||
                 (collecting && (byte_class != BYTE_DATA) && not_empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= RX_COLLECT;
      count_reg      <= 5'd0;
      line_valid_reg <= 1'b0;
      line_len_reg   <= 5'd0;
      echo_wr_reg    <= 1'b0;
      echo_byte_reg  <= 8'h00;
      overflow_reg   <= 1'b0;
      drop_reg       <= 1'b0;
    end else begin
      echo_wr_reg  <= 1'b0;
      overflow_reg <= 1'b0;
      drop_reg     <= 1'b0;

      if (echo_due) begin
        if (echo_full) begin
          drop_reg <= 1'b1;
        end else begin
          echo_wr_reg   <= 1'b1;
          echo_byte_reg <= rx_byte;
        end
      end

      case (state_reg)
        RX_COLLECT: begin
          if (rx_valid) begin
            case (byte_class)
              BYTE_EOL: begin
                if (not_empty) begin
                  state_reg      <= RX_HOLD;
                  line_valid_reg <= 1'b1;
                  line_len_reg   <= count_reg;
                end
              end
              BYTE_BS: begin
                if (not_empty) count_reg <= count_reg - 5'd1;
              end
              default: begin
                if (has_room) begin
                  count_reg <= count_reg + 5'd1;
                end else begin
                  overflow_reg <= 1'b1;
                  state_reg    <= RX_DISCARD;
                end
              end
            endcase
          end
        end
        RX_HOLD: begin
          // A byte arriving while the line is held is always lost, even alongside an ack.
          if (rx_valid) drop_reg <= 1'b1;
          if (line_ack) begin
            state_reg      <= RX_COLLECT;
            count_reg      <= 5'd0;
            line_valid_reg <= 1'b0;
          end
        end
        RX_DISCARD: begin
          if (rx_valid && (byte_class == BYTE_EOL)) begin
            state_reg <= RX_COLLECT;
            count_reg <= 5'd0;
          end
        end
        default: begin
          state_reg <= RX_COLLECT;
          count_reg <= 5'd0;
        end
      endcase
    end
  end

  line_ram #(
    .DEPTH(DEPTH),
    .AW   (4)
  ) u_line_ram (
    .clk    (clk),
    .we     (store),
    .wr_addr(count_reg[3:0]),
    .wr_data(rx_byte),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  assign echo_wr    = echo_wr_reg;
  assign echo_byte  = echo_byte_reg;
  assign line_valid = line_valid_reg;
  assign line_len   = line_len_reg;
  assign overflow   = overflow_reg;
  assign drop       = drop_reg;

endmodule

// File: doc/rx_line_buffer.md
RX_LINE_BUFFER -- requirements
Module: rx_line_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, maximum line length in bytes.
REQ-002 SHALL have parameter EOL, default 8'h0D, line terminator byte.
REQ-003 SHALL have parameter BS, default 8'h08, backspace byte.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe: rx_byte is a newly received byte from the uart.
REQ-007 SHALL have port rx_byte  input  8  received byte.
REQ-008 SHALL have port echo_full  input  1  downstream tx fifo full.
REQ-009 SHALL have port echo_wr  output  1  one-cycle write strobe into the tx fifo.
REQ-010 SHALL have port echo_byte  output  8  byte to echo.
REQ-011 SHALL have port line_valid  output  1  a complete line is held for the consumer.
REQ-012 SHALL have port line_len  output  5  number of bytes in the held line, 1..DEPTH.
REQ-013 SHALL have port rd_addr  input  4  consumer read index.
REQ-014 SHALL have port rd_data  output  8  buffer byte at rd_addr, combinational.
REQ-015 SHALL have port line_ack  input  1  consumer has finished with the held line.
REQ-016 SHALL have port overflow  output  1  one-cycle pulse on line overflow.
REQ-017 SHALL have port drop  output  1  one-cycle pulse when a byte or echo is discarded.

Function
REQ-018 SHALL implement states COLLECT, HOLD, DISCARD; the reset state is COLLECT.
REQ-019 In COLLECT, a non-EOL, non-BS byte with count<DEPTH SHALL be written to buf[count] and count SHALL increment.
REQ-020 In COLLECT, a non-EOL, non-BS byte with count==DEPTH SHALL pulse overflow the next cycle, SHALL NOT be stored, and SHALL move to DISCARD.
REQ-021 In COLLECT, BS with count>0 SHALL decrement count; BS with count==0 SHALL be ignored and not echoed.
REQ-022 In COLLECT, EOL with count>0 SHALL move to HOLD, with line_valid=1 and line_len=count from the next cycle.
REQ-023 In COLLECT, EOL with count==0 SHALL be ignored and SHALL produce no line_valid.
REQ-024 In DISCARD, all bytes SHALL be ignored without echo; EOL SHALL return to COLLECT with count=0.
REQ-025 In HOLD, rx_valid SHALL pulse drop and discard the byte; buffer contents and line_len SHALL stay stable.
REQ-026 In HOLD, line_ack SHALL return to COLLECT with count=0; line_valid SHALL deassert the next cycle.
REQ-027 If line_ack and rx_valid occur in the same HOLD cycle, the ack SHALL be processed and the byte dropped.
REQ-028 Every byte stored, every BS that decrements, and every accepted EOL SHALL be echoed: echo_wr pulses one cycle after rx_valid, carrying that byte.
REQ-029 When an echo is due while echo_full=1, echo_wr SHALL stay 0 and drop SHALL pulse; no retry.
REQ-030 line_ack outside HOLD SHALL be ignored.
REQ-031 rd_data SHALL equal buf[rd_addr] for any rd_addr; only indices below line_len are defined content.
REQ-032 count SHALL be 5 bits and SHALL never exceed DEPTH or wrap below 0.

Reset
REQ-033 Asserting rst SHALL asynchronously force state=COLLECT, count=0, line_valid=0, line_len=0, echo_wr=0, echo_byte=0, overflow=0, drop=0.
REQ-034 Buffer storage SHALL NOT require reset.
REQ-035 Reset in any state, including mid-line or HOLD, SHALL abandon the partial or held line.

Structure
REQ-036 EOL and BS defaults and the state encoding SHALL live in a shared uart package used by the tx and rx paths.
REQ-037 The byte storage SHALL be a sub-module, line_ram: DEPTH x 8, one synchronous write port and one asynchronous read port.

Verification
REQ-038 Send "AB",EOL -> line_valid=1, line_len=2, rd_data[0]=8'h41, rd_data[1]=8'h42; three echo_wr pulses carrying 41,42,0D.
REQ-039 Send "ABC",BS,"D",EOL -> line_len=3, contents 41,42,44; BS echoed; then BS at count 0 -> no echo, no state change.
REQ-040 Send 17 non-EOL bytes -> overflow pulse after the 17th; send "X",EOL -> no line_valid; then "Q",EOL -> line_len=1.
REQ-041 While in HOLD, send "Z" together with line_ack -> drop pulse; next line starts empty.
REQ-042 Hold echo_full=1 and send "A" -> no echo_wr, drop pulse, byte still stored.
REQ-043 Assert rst after "AB" -> count=0, line_valid=0; then "C",EOL -> line_len=1, rd_data[0]=8'h43.
